truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequential upstream/downstream harness for a 4-input combinational function stage.
- Walks the 4-bit code a,b,c,d through minterms 0..15 and drives the function stage's inputs and enable.
- After a programmable settle time per code, samples the returned f and assembles a 16-bit truth table plus a popcount.
- Start/busy/done handshake; used for in-lab self-check of the decoder-based function blocks.

Parameters:
- SETTLE_CYCLES, 1, cycles code is held before f is sampled; legal range 1..15; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- start  input  1  request a scan; sampled only in IDLE
- abort  input  1  cancel a scan in progress; ignored in IDLE
- f_in  input  1  function output returned from the function stage
- abcd  output  4  code to the function stage; abcd[3]=a (MSB), abcd[0]=d
- en  output  1  function-stage enable; 1 only while scanning
- busy  output  1  1 in SETTLE/SAMPLE states
- done  output  1  one-cycle pulse when a full scan completes
- truth_table  output  16  bit k = f sampled with abcd=k
- ones_count  output  5  number of 1s in truth_table (0..16)
- table_valid  output  1  1 once a complete scan has finished; cleared at start/abort

Behaviour:
- Reset (nrst=0, async, any state): state=IDLE.
  - abcd=0, en=0, busy=0, done=0.
  - truth_table=0, ones_count=0, table_valid=0.
  - Settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. Registered outputs, Moore style.
- IDLE, start=1 -> SETTLE on the next edge.
  - Same edge: code=0, en=1, truth_table=0, ones_count=0, table_valid=0, settle counter=SETTLE_CYCLES-1.
- SETTLE: abcd=code held stable, en=1, busy=1.
  - Counter decrements each cycle.
  - When counter==0 -> SAMPLE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): f_in registered into truth_table[code] at the end of the cycle; ones_count += f_in.
  - If code==15 -> DONE, with en=0 and abcd=0 on the same edge.
  - Else code+1 -> SETTLE, counter reloaded to SETTLE_CYCLES-1.
- DONE (1 cycle): done=1, busy=0, table_valid=1 set on entry; next state IDLE.
  - start during DONE is ignored.
- Latency: start edge to done pulse = 16*(SETTLE_CYCLES+1) cycles after the SETTLE entry edge.
  - 32 cycles for the default.
  - done asserts in cycle 16*(S+1)+1 relative to the start-sample edge.
- abort=1 in SETTLE or SAMPLE -> IDLE next edge.
  - en=0, abcd=0, busy=0, table_valid=0.
  - truth_table/ones_count keep partial contents but are flagged invalid; no done pulse.
  - abort has priority over the SAMPLE capture on the same edge: no write.
- abort and start both high in IDLE: start wins (abort ignored in IDLE).
- Results are stable in IDLE until the next start; no wrap of code beyond 15.
- Width rules: code is a 4-bit register; ones_count is 5 bits and saturates naturally at 16 (cannot overflow).
- f_in is assumed combinationally derived from abcd/en; no synchronizer is required.

Decomposition:
- Shared package/header truth_scan_defs:
  - 2-bit state encodings (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3).
  - CODE_W=4, TABLE_W=16.
- One natural sub-module: scan_settle_timer.
  - 4-bit loadable down-counter with load, value and zero flag.
  - Instantiated once; the FSM, code register and table accumulation stay in the top.

Test Plan:
- Reset mid-scan: assert nrst=0 asynchronously during SETTLE of code 7 -> all outputs read 0 immediately, before any clock edge; state IDLE after release.
- Prime-detector function (f=1 for 2,3,5,7,11,13), default SETTLE_CYCLES=1, pulse start -> done pulses exactly once, 33 cycles after the start edge.
  - truth_table=16'h28AC, ones_count=6, table_valid=1.
- Constant f_in=1 with SETTLE_CYCLES=3 -> abcd steps 0..15, each held 4 cycles (3 SETTLE + 1 SAMPLE).
  - truth_table=16'hFFFF, ones_count=16, done at 64 cycles + 1.
- Abort asserted in the SAMPLE cycle of code 5 -> bit 5 not written, no done, table_valid=0, en=0 next cycle.
  - A following start rescans cleanly, giving the full correct table.
- start held high continuously -> a new scan starts only from IDLE: the done pulse is followed by one IDLE cycle, then SETTLE again with the table cleared.
- start pulse while busy (code 9) -> ignored; scan completes normally with the unchanged result and a single done.

Source files
------------

// File: rtl/truth_scan_defs.sv
// rtl/truth_scan_defs.sv - shared state encodings and widths for the truth table scanner
package truth_scan_defs;

  localparam int CODE_W  = 4;
  localparam int TABLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// rtl/scan_settle_timer.sv - loadable 4-bit down-counter timing how long each code is held
module scan_settle_timer
  import truth_scan_defs::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [CODE_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [CODE_W-1:0] count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks a 4-input function stage through all 16 codes and
// assembles its truth table and popcount
module truth_table_scanner
  import truth_scan_defs::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               abort,
  input  logic               f_in,
  output logic [CODE_W-1:0]  abcd,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] truth_table,
  output logic [4:0]         ones_count,
  output logic               table_valid
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CODE_W-1:0] SETTLE_RELOAD = CODE_W'(SETTLE_CYCLES - 1);

  scan_state_t       state, state_next;
  logic [CODE_W-1:0] code;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              do_clear, do_capture, do_advance, do_finish, do_abort;

  scan_settle_timer u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (tmr_load),
    .load_val (SETTLE_RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    do_advance = 1'b0;
    do_finish  = 1'b0;
    do_abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          tmr_load   = 1'b1;
          do_clear   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_next = ST_IDLE;
          do_abort   = 1'b1;
        end else if (tmr_zero) begin
          state_next = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // abort wins over the capture, so the in-flight bit is never written
        if (abort) begin
          state_next = ST_IDLE;
          do_abort   = 1'b1;
        end else begin
          do_capture = 1'b1;
          if (code == CODE_W'(TABLE_W - 1)) begin
            state_next = ST_DONE;
            do_finish  = 1'b1;
          end else begin
            state_next = ST_SETTLE;
            tmr_load   = 1'b1;
            do_advance = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      code        <= '0;
      truth_table <= '0;
      ones_count  <= '0;
      table_valid <= 1'b0;
    end else begin
      if (do_clear) begin
        code        <= '0;
        truth_table <= '0;
        ones_count  <= '0;
        table_valid <= 1'b0;
      end
      if (do_capture) begin
        truth_table[code] <= f_in;
        ones_count        <= ones_count + {4'b0000, f_in};
      end
      if (do_advance) code <= code + 1'b1;
      if (do_finish) begin
        code        <= '0;
        table_valid <= 1'b1;
      end
      if (do_abort) begin
        code        <= '0;
        table_valid <= 1'b0;
      end
    end
  end

  assign abcd = code;
  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign en   = busy;
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start1 = 1'b0, abort1 = 1'b0, f_in1;
  logic        start3 = 1'b0, abort3 = 1'b0, f_in3 = 1'b1;
  logic [3:0]  abcd1, abcd3;
  logic        en1, busy1, done1, tv1;
  logic        en3, busy3, done3, tv3;
  logic [15:0] tt1, tt3;
  logic [4:0]  oc1, oc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // prime detector: f=1 for 2,3,5,7,11,13, gated by the enable
  assign f_in1 = en1 && (abcd1 == 4'd2 || abcd1 == 4'd3 || abcd1 == 4'd5 ||
                         abcd1 == 4'd7 || abcd1 == 4'd11 || abcd1 == 4'd13);

  truth_table_scanner dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .abort(abort1), .f_in(f_in1),
    .abcd(abcd1), .en(en1), .busy(busy1), .done(done1),
    .truth_table(tt1), .ones_count(oc1), .table_valid(tv1)
  );

  truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .nrst(nrst), .start(start3), .abort(abort3), .f_in(f_in3),
    .abcd(abcd3), .en(en3), .busy(busy3), .done(done3),
    .truth_table(tt3), .ones_count(oc3), .table_valid(tv3)
  );

  // pulses start1 for one edge, then watches n_edges edges for done pulses
  task automatic run_scan1(input int n_edges, output int first_done, output int n_done);
    first_done = -1;
    n_done = 0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk); #1;
      if (done1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({abcd1, en1, busy1, done1, tt1, oc1, tv1} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", {abcd1, en1, busy1, done1, tt1, oc1, tv1});
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_prime_scan;
    int first_done, n_done;
    run_scan1(40, first_done, n_done);
    checks++;
    if (first_done !== 32) begin
      failures++;
      $display("FAIL prime_latency got %0d want 32", first_done);
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL prime_done_count got %0d want 1", n_done);
    end
    checks++;
    if (tt1 !== 16'h28AC) begin
      failures++;
      $display("FAIL prime_table got %h want 28ac", tt1);
    end
    checks++;
    if (oc1 !== 5'd6 || tv1 !== 1'b1) begin
      failures++;
      $display("FAIL prime_count_valid got %0d/%0b want 6/1", oc1, tv1);
    end
  endtask

  task automatic test_reset_mid_scan;
    bit seen = 0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (abcd1 == 4'd7 && busy1) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_reach_code7 got 0 want 1");
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({abcd1, en1, busy1, done1, tt1, oc1, tv1} !== 29'd0) begin
      failures++;
      $display("FAIL reset_mid_async got %h want 0", {abcd1, en1, busy1, done1, tt1, oc1, tv1});
    end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || en1 !== 1'b0 || abcd1 !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_idle got busy=%0b en=%0b abcd=%0d want 0/0/0", busy1, en1, abcd1);
    end
  endtask

  task automatic test_const_settle3;
    int bad_steps = 0;
    int first_done = -1;
    int n_done = 0;
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    if (abcd3 !== 4'd0 || !busy3) bad_steps++;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k < 64 && (abcd3 !== 4'(k / 4) || !en3)) bad_steps++;
      if (done3) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
    checks++;
    if (bad_steps !== 0) begin
      failures++;
      $display("FAIL s3_code_hold got %0d bad cycles want 0", bad_steps);
    end
    checks++;
    if (first_done !== 64 || n_done !== 1) begin
      failures++;
      $display("FAIL s3_done got edge %0d count %0d want 64/1", first_done, n_done);
    end
    checks++;
    if (tt3 !== 16'hFFFF || oc3 !== 5'd16 || tv3 !== 1'b1) begin
      failures++;
      $display("FAIL s3_result got %h/%0d/%0b want ffff/16/1", tt3, oc3, tv3);
    end
  endtask

  task automatic test_abort_sample;
    bit seen = 0;
    int n_done = 0;
    int first_done, n_done2;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (abcd1 == 4'd5 && busy1) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    // first cycle at code 5 is SETTLE; with one settle cycle the next is SAMPLE
    @(posedge clk); #1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || en1 !== 1'b0 || tv1 !== 1'b0 || abcd1 !== 4'd0) begin
      failures++;
      $display("FAIL abort_state got busy=%0b en=%0b tv=%0b abcd=%0d want 0/0/0/0",
               busy1, en1, tv1, abcd1);
    end
    checks++;
    if (tt1 !== 16'h000C || oc1 !== 5'd2) begin
      failures++;
      $display("FAIL abort_partial got %h/%0d want 000c/2", tt1, oc1);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d want 0", n_done);
    end
    run_scan1(40, first_done, n_done2);
    checks++;
    if (tt1 !== 16'h28AC || oc1 !== 5'd6 || n_done2 !== 1 || tv1 !== 1'b1) begin
      failures++;
      $display("FAIL abort_rescan got %h/%0d/%0d/%0b want 28ac/6/1/1", tt1, oc1, n_done2, tv1);
    end
  endtask

  task automatic test_start_held;
    bit seen = 0;
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int k = 0; k < 45 && !seen; k++) begin
      @(posedge clk); #1;
      if (done1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL held_done got 0 want 1");
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || tv1 !== 1'b1 || tt1 !== 16'h28AC) begin
      failures++;
      $display("FAIL held_idle_gap got busy=%0b done=%0b tv=%0b tt=%h want 0/0/1/28ac",
               busy1, done1, tv1, tt1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b1 || tv1 !== 1'b0 || tt1 !== 16'h0000 || abcd1 !== 4'd0) begin
      failures++;
      $display("FAIL held_restart got busy=%0b tv=%0b tt=%h abcd=%0d want 1/0/0000/0",
               busy1, tv1, tt1, abcd1);
    end
    start1 = 1'b0;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL held_abort got busy=%0b want 0", busy1);
    end
  endtask

  task automatic test_start_while_busy;
    bit injected = 0;
    int first_done = -1;
    int n_done = 0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (abcd1 == 4'd9 && !injected) begin
        start1 = 1'b1;
        injected = 1;
      end else begin
        start1 = 1'b0;
      end
    end
    checks++;
    if (first_done !== 32 || n_done !== 1) begin
      failures++;
      $display("FAIL busy_start_done got edge %0d count %0d want 32/1", first_done, n_done);
    end
    checks++;
    if (tt1 !== 16'h28AC || oc1 !== 5'd6 || tv1 !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_result got %h/%0d/%0b want 28ac/6/1", tt1, oc1, tv1);
    end
  endtask

  initial begin
    test_reset;
    test_prime_scan;
    test_reset_mid_scan;
    test_const_settle3;
    test_abort_sample;
    test_start_held;
    test_start_while_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
